// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: PS/2 line inputs and decoded key-event outputs.
// Ports: ps2_clk, ps2_data (device lines, idle high); ps2_key (11-bit event word); error (1-cycle pulse).
// master = PS/2 device / driver side, slave = decoder side.
interface ps2_key_decoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        error;
    modport master (output ps2_clk, ps2_data, input ps2_key, error);
    modport slave  (input ps2_clk, ps2_data, output ps2_key, error);
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard frame receiver and scan-code event decoder.
// Ports: clk (system clock), reset (async, active high),
//        bus (slave): ps2_clk/ps2_data in, ps2_key {toggle, pressed, extended, code} and error out.
module ps2_key_decoder #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 9600
) (
    input  logic              clk,
    input  logic              reset,
    ps2_key_decoder_if.slave  bus
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state, state_n;
    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           flt, flt_d, fall;
    logic [FW-1:0]  fcnt;
    logic [TW-1:0]  to_cnt;
    logic           timeout;
    logic [7:0]     sr;
    logic [2:0]     bit_cnt;
    logic           par;
    logic           frame_ok, frame_bad;
    logic           byte_valid, err_q;
    logic           brk, ext;
    logic           discard;
    logic [10:0]    key;

    assign bus.ps2_key = key;
    assign bus.error   = err_q;

    // Synchronizers and glitch filter: the filtered level only follows the
    // synchronized clock after FILTER consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {clk_s1, clk_s2, dat_s1, dat_s2, flt, flt_d} <= '1;
            fcnt <= '0;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
            flt_d  <= flt;
            if (clk_s2 == flt)
                fcnt <= '0;
            else if (fcnt == FW'(FILTER - 1)) begin
                flt  <= clk_s2;
                fcnt <= '0;
            end else
                fcnt <= fcnt + 1'b1;
        end
    end

    assign fall    = flt_d & ~flt;
    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT));
    assign discard = sr inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout)
            state_n = IDLE;
        else if (fall) begin
            case (state)
                IDLE:    state_n = dat_s2 ? IDLE : DATA;
                DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_n = STOP;
                default: begin
                    state_n   = IDLE;
                    frame_ok  = dat_s2 & (^{sr, par});
                    frame_bad = ~frame_ok;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt     <= '0;
            sr         <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            byte_valid <= 1'b0;
            err_q      <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            key        <= '0;
        end else begin
            byte_valid <= frame_ok;
            err_q      <= frame_bad;
            to_cnt     <= (state_n == IDLE || fall) ? '0 : to_cnt + 1'b1;
            if (fall && state == IDLE)
                bit_cnt <= '0;
            if (fall && state == DATA) begin
                sr      <= {dat_s2, sr[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall && state == PARITY)
                par <= dat_s2;
            // sr still holds the received byte while byte_valid is high:
            // the next shift cannot happen before another filtered fall.
            if (err_q)
                {brk, ext} <= 2'b00;
            else if (byte_valid) begin
                if (sr == 8'hF0)
                    brk <= 1'b1;
                else if (sr == 8'hE0)
                    ext <= 1'b1;
                else begin
                    {brk, ext} <= 2'b00;
                    if (!discard)
                        key <= {~key[10], ~brk, ext, sr};
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized and directed PS/2 frames checked against a key-event model.
module tb_ps2_key_decoder;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 600;
    localparam int H       = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    ps2_key_decoder_if bus();

    ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, err_cnt = 0, chg_cyc = 0, stop_cyc = 0;
    logic [10:0] last_key = '0;

    logic [10:0] exp_key = '0;
    bit exp_brk = 0, exp_ext = 0;
    byte unsigned discard_list[8] = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.error) err_cnt++;
        if (bus.ps2_key !== last_key) begin
            chg_cyc  = cyc;
            last_key = bus.ps2_key;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit is_discard(input byte unsigned b);
        foreach (discard_list[i]) if (discard_list[i] == b) return 1;
        return 0;
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            wait_cyc(H);
            bus.ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(H);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        wait_cyc(1);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        exp_key = '0;
        exp_brk = 0;
        exp_ext = 0;
        wait_cyc(3);
    endtask

    // Sends one frame, advances the model, and checks key, error pulses and event latency.
    task automatic frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        int err_base;
        bit ev;
        bit bad;
        err_base = err_cnt;
        bad = bad_par | bad_stop;
        ev = 0;
        send_bits(frame_bits(b, bad_par, bad_stop), 11);
        wait_cyc(30);
        if (bad) begin
            exp_brk = 0;
            exp_ext = 0;
        end else if (b == 8'hF0)
            exp_brk = 1;
        else if (b == 8'hE0)
            exp_ext = 1;
        else begin
            if (!is_discard(b)) begin
                ev = 1;
                exp_key = {~exp_key[10], ~exp_brk, exp_ext, b};
            end
            exp_brk = 0;
            exp_ext = 0;
        end
        check($sformatf("key[%02h]", b), bus.ps2_key, exp_key);
        check($sformatf("err[%02h]", b), err_cnt - err_base, bad ? 1 : 0);
        // 2 synchronizer flops + FILTER filter cycles + fall cycle + byte_valid cycle
        if (ev) check($sformatf("lat[%02h]", b), chg_cyc - stop_cyc, FILTER + 4);
    endtask

    initial begin
        int err_base;
        logic [10:0] bits;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        #2;
        check("rst_key", bus.ps2_key, 11'h000);
        check("rst_err", bus.error, 1'b0);
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(3);

        frame(8'h1C);
        check("basic_1c", bus.ps2_key, 11'h61C);
        frame(8'hF0);
        frame(8'h1C);

        do_reset();
        frame(8'hE0);
        frame(8'h75);
        check("ext_75", bus.ps2_key, 11'h775);
        frame(8'h1C);

        do_reset();
        frame(8'hF0);
        frame(8'h1C, 1, 0);
        check("bad_par_key", bus.ps2_key, 11'h000);
        frame(8'h1C);
        check("after_bad", bus.ps2_key, 11'h61C);
        frame(8'h33, 0, 1);

        // Glitch one cycle shorter than the filter, with data low to look like a start bit
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        wait_cyc(FILTER - 1);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(30);
        frame(8'h4D);

        err_base = err_cnt;
        send_bits(frame_bits(8'h5A, 0, 0), 5);
        wait_cyc(TIMEOUT + 10);
        check("tmo_key", bus.ps2_key, exp_key);
        check("tmo_err", err_cnt - err_base, 0);
        frame(8'h29);
        check("after_tmo", bus.ps2_key, {exp_key[10], 10'h229});

        frame(8'hF0);
        frame(8'hE0);
        err_base = err_cnt;
        send_bits(frame_bits(8'h11, 0, 0), 4);
        wait_cyc(TIMEOUT + 10);
        check("tmo2_err", err_cnt - err_base, 0);
        frame(8'hF0);
        frame(8'h1C);
        frame(8'hAA);
        frame(8'h1C);

        // Asynchronous reset while bit 4 of a frame is being clocked
        err_base = err_cnt;
        bits = frame_bits(8'h55, 0, 0);
        send_bits(bits, 5);
        bus.ps2_data = bits[5];
        wait_cyc(H);
        bus.ps2_clk = 1'b0;
        wait_cyc(5);
        #3 reset = 1'b1;
        #1;
        check("areset_key", bus.ps2_key, 11'h000);
        check("areset_err", bus.error, 1'b0);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        exp_key = '0;
        exp_brk = 0;
        exp_ext = 0;
        wait_cyc(3);
        check("areset_noerr", err_cnt - err_base, 0);
        frame(8'h16);
        check("after_areset", bus.ps2_key, 11'h616);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            int r;
            bit bp, bs;
            r = int'($urandom_range(0, 9));
            b = (r < 2) ? 8'hF0 : (r == 2) ? 8'hE0 :
                (r == 3) ? 8'(discard_list[$urandom_range(0, 7)]) : 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 14) == 0);
            frame(b, bp, bs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
